// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the keypad scanner: FSM state encoding,
// the 16-entry key map and the column decode used at each sample point.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_HOLD     = 2'd3
    } scan_state_t;

    // Layout:  r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Returns {single, col}: single is set when exactly one column reads low.
    function automatic logic [2:0] decode_cols(input logic [3:0] cols);
        logic [2:0] res;
        case (cols)
            4'b1110: res = {1'b1, 2'd0};
            4'b1101: res = {1'b1, 2'd1};
            4'b1011: res = {1'b1, 2'd2};
            4'b0111: res = {1'b1, 2'd3};
            default: res = {1'b0, 2'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parameterised-width two-flop synchronizer for asynchronous level inputs.
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce; emits one push strobe
// (or a drop strobe under backpressure) per accepted key press.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rows rotate each dwell period, looking for a single low column
// DEBOUNCE | row frozen, counting consecutive agreeing samples
// EMIT     | one cycle: register code and issue valid/dropped strobe
// HOLD     | row frozen, waiting for DEBOUNCE_CNT clean release samples
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 250000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] keypad_rows,
    input  logic [3:0] keypad_cols,
    input  logic       full,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_dropped
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_DONE   = BW'(DEBOUNCE_CNT);

    scan_state_t   state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] deb_q, deb_d;
    logic [BW-1:0] rel_q, rel_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    lat_col_q, lat_col_d;
    logic [3:0]    rows_d;
    logic [3:0]    code_d;
    logic          valid_d, dropped_d, held_d;

    logic [3:0]    cols_sync;
    logic          sample;
    logic [2:0]    col_dec;
    logic          single;
    logic [1:0]    hit_col;

    sync2 #(
        .WIDTH   (4),
        .RST_VAL (4'b1111)
    ) u_sync_cols (
        .clk (clk),
        .rst (rst),
        .d   (keypad_cols),
        .q   (cols_sync)
    );

    assign sample  = (dwell_q == DWELL_LAST);
    assign col_dec = decode_cols(cols_sync);
    assign single  = col_dec[2];
    assign hit_col = col_dec[1:0];

    always_comb begin
        state_d   = state_q;
        dwell_d   = sample ? '0 : dwell_q + DW'(1);
        deb_d     = deb_q;
        rel_d     = rel_q;
        row_d     = row_q;
        lat_col_d = lat_col_q;
        code_d    = key_code;
        valid_d   = 1'b0;
        dropped_d = 1'b0;
        held_d    = key_held;

        case (state_q)
            ST_SCAN: begin
                if (sample) begin
                    if (single) begin
                        lat_col_d = hit_col;
                        // A one-sample acceptance threshold skips straight to EMIT.
                        if (DEBOUNCE_CNT == 1) begin
                            deb_d   = '0;
                            state_d = ST_EMIT;
                        end else begin
                            deb_d   = BW'(1);
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (sample) begin
                    if (single && (hit_col == lat_col_q)) begin
                        if ((deb_q + BW'(1)) == DEB_DONE) begin
                            deb_d   = '0;
                            state_d = ST_EMIT;
                        end else begin
                            deb_d = deb_q + BW'(1);
                        end
                    end else begin
                        deb_d   = '0;
                        row_d   = row_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_EMIT: begin
                code_d    = key_map(row_q, lat_col_q);
                valid_d   = ~full;
                dropped_d = full;
                held_d    = 1'b1;
                rel_d     = '0;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (sample) begin
                    if (cols_sync == 4'b1111) begin
                        if ((rel_q + BW'(1)) == DEB_DONE) begin
                            held_d  = 1'b0;
                            rel_d   = '0;
                            row_d   = 2'd0;
                            state_d = ST_SCAN;
                        end else begin
                            rel_d = rel_q + BW'(1);
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase

        rows_d = ~(4'b0001 << row_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            dwell_q     <= '0;
            deb_q       <= '0;
            rel_q       <= '0;
            row_q       <= 2'd0;
            lat_col_q   <= 2'd0;
            keypad_rows <= 4'b1111;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_dropped <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            rel_q       <= rel_d;
            row_q       <= row_d;
            lat_col_q   <= lat_col_d;
            keypad_rows <= rows_d;
            key_code    <= code_d;
            key_valid   <= valid_d;
            key_held    <= held_d;
            key_dropped <= dropped_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural keypad matrix and key map model.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  keypad_rows;
    logic [3:0]  keypad_cols;
    logic        full = 1'b0;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        key_dropped;

    logic [15:0] pressed = '0;
    int          tests = 0;
    int          fails = 0;
    logic [4:0]  exp_q[$];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .keypad_rows (keypad_rows),
        .keypad_cols (keypad_cols),
        .full        (full),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .key_dropped (key_dropped)
    );

    // Matrix: a pressed key shorts its column low while its row is driven low.
    always_comb begin
        keypad_cols = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !keypad_rows[r]) keypad_cols[c] = 1'b0;
    end

    function automatic logic [3:0] ref_code(input int idx);
        string legend;
        int    ch;
        legend = "123A456B789C*0#D";
        ch = int'(legend[idx]);
        if (ch >= 48 && ch <= 57) return 4'(ch - 48);
        if (ch >= 65 && ch <= 68) return 4'(ch - 65 + 10);
        if (ch == 42) return 4'hE;
        return 4'hF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (key_valid || key_dropped)) begin
            check("strobe_exclusive", {31'd0, key_valid & key_dropped}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got valid=%0b dropped=%0b code=%0h, expected none",
                         key_valid, key_dropped, key_code);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check("strobe_kind_code", {27'd0, key_dropped, key_code}, {27'd0, e});
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_rows"},    {28'd0, keypad_rows}, 32'hF);
        check({tag, "_code"},    {28'd0, key_code},    32'h0);
        check({tag, "_valid"},   {31'd0, key_valid},   32'h0);
        check({tag, "_held"},    {31'd0, key_held},    32'h0);
        check({tag, "_dropped"}, {31'd0, key_dropped}, 32'h0);
    endtask

    task automatic wait_held(input logic v, input int budget, input string name);
        int n;
        n = 0;
        while (key_held !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, key_held}, {31'd0, v});
    endtask

    task automatic press_key(input int idx, input logic f, input int hold, input bit bounce);
        full = f;
        exp_q.push_back({f, ref_code(idx)});
        if (bounce) begin
            repeat (3) begin
                pressed[idx] = 1'b1;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                pressed[idx] = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
        pressed[idx] = 1'b1;
        wait_held(1'b1, 300, "held_rise");
        repeat (hold) @(negedge clk);
        check("held_while_pressed", {31'd0, key_held}, 32'd1);
        pressed[idx] = 1'b0;
        repeat (6) @(negedge clk);
        check("held_before_release_confirm", {31'd0, key_held}, 32'd1);
        wait_held(1'b0, 100, "held_fall");
        check("rows_resume_row0", {28'd0, keypad_rows}, 32'hE);
        check("code_stable", {28'd0, key_code}, {28'd0, ref_code(idx)});
        full = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] one;
        one = 4'b0001;

        // Idle scan: rows rotate every SCAN_DIV cycles starting at row 0.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("idle_rows", {28'd0, keypad_rows}, {28'd0, ~(one << ((k / SCAN_DIV) % 4))});
        end

        press_key(5, 1'b0, 20, 1'b0);    // '5'
        press_key(14, 1'b0, 20, 1'b1);   // '#' with bounce
        press_key(15, 1'b1, 20, 1'b0);   // 'D' under backpressure

        // '9' pressed during HOLD of '1' is invisible; both released before confirm.
        exp_q.push_back({1'b0, ref_code(0)});
        pressed[0] = 1'b1;
        wait_held(1'b1, 300, "held_rise_1");
        repeat (5) @(negedge clk);
        pressed[10] = 1'b1;
        repeat (20) @(negedge clk);
        pressed[0] = 1'b0;
        repeat (2) @(negedge clk);
        pressed[10] = 1'b0;
        wait_held(1'b0, 100, "held_fall_1");
        repeat (60) @(negedge clk);
        check("no_second_emit", {28'd0, key_code}, {28'd0, ref_code(0)});

        // Two columns low on the same row never qualify as a press.
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        repeat (80) @(negedge clk);
        check("double_col_no_held", {31'd0, key_held}, 32'd0);
        pressed = '0;
        repeat (10) @(negedge clk);

        // Reset in the middle of debounce: row 0 key is in DEBOUNCE after 6 cycles.
        do_reset();
        pressed[0] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        pressed = '0;
        @(negedge clk);
        check_reset_vals("rst_debounce");
        rst = 1'b0;
        @(negedge clk);
        check("rst_debounce_row0", {28'd0, keypad_rows}, 32'hE);
        repeat (40) @(negedge clk);

        // Reset in the middle of HOLD.
        exp_q.push_back({1'b0, ref_code(5)});
        pressed[5] = 1'b1;
        wait_held(1'b1, 300, "held_rise_rst");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        pressed = '0;
        @(negedge clk);
        check_reset_vals("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check("rst_hold_row0", {28'd0, keypad_rows}, 32'hE);
        repeat (40) @(negedge clk);

        // Randomised presses against the key map model.
        for (int i = 0; i < 12; i++) begin
            press_key(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(10, 40)), 1'($urandom_range(0, 1)));
        end

        repeat (50) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
